dma_master_apb3: RTL and testbench



---
 rtl/dma_master_apb3.sv | 134 +++++++++++++
 tb/tb_dma_master_apb3.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dma_master_apb3.sv
// APB3 initiator for the DMA controller: one SETUP/ACCESS transfer per accepted command.
// Optional ACCESS-phase timeout is compiled in with `define DMA_MASTER_APB3_TIMEOUT_EN.
module dma_master_apb3 #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        i_clk,
  input  logic        i_pnreset,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic [31:0] i_req_addr,
  input  logic        i_req_write,
  input  logic [31:0] i_req_wdata,
  output logic        o_rsp_valid,
  input  logic        i_rsp_ready,
  output logic [31:0] o_rsp_rdata,
  output logic        o_rsp_err,
  output logic        o_psel,
  output logic        o_penable,
  output logic [31:0] o_paddr,
  output logic        o_pwrite,
  output logic [31:0] o_pwdata,
  input  logic        i_pready,
  input  logic        i_pslverr,
  input  logic [31:0] i_prdata,
  output logic        o_busy
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_ACCESS,
    ST_RESP
  } state_t;

  state_t state_q, state_d;
  logic   accept;
  logic   complete;
  logic   timed_out;

  assign accept   = (state_q == ST_IDLE) && i_req_valid;
  assign complete = (state_q == ST_ACCESS) && i_pready;

  // A TIMEOUT outside the 16-bit counter range cannot be represented.
  assert property (@(posedge i_clk) (TIMEOUT >= 1) && (TIMEOUT <= 65535));

`ifdef DMA_MASTER_APB3_TIMEOUT_EN
  localparam logic [15:0] WAIT_LIMIT = 16'(TIMEOUT - 1);

  logic [15:0] wait_cnt_q;

  // The limit cycle itself counts as a wait; i_pready=1 there still completes normally.
  assign timed_out = (state_q == ST_ACCESS) && !i_pready && (wait_cnt_q == WAIT_LIMIT);

  always_ff @(posedge i_clk or negedge i_pnreset) begin
    if (!i_pnreset) begin
      wait_cnt_q <= '0;
    end else if (state_q == ST_SETUP) begin
      wait_cnt_q <= '0;
    end else if ((state_q == ST_ACCESS) && !i_pready) begin
      wait_cnt_q <= wait_cnt_q + 16'd1;
    end
  end
`else
  assign timed_out = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge i_clk or negedge i_pnreset) begin
    if (!i_pnreset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d     = state_q;
    o_req_ready = 1'b0;
    o_psel      = 1'b0;
    o_penable   = 1'b0;
    o_rsp_valid = 1'b0;
    o_busy      = 1'b1;
    unique case (state_q)
      ST_IDLE: begin
        o_req_ready = 1'b1;
        o_busy      = 1'b0;
        if (i_req_valid) state_d = ST_SETUP;
      end
      ST_SETUP: begin
        o_psel  = 1'b1;
        state_d = ST_ACCESS;
      end
      ST_ACCESS: begin
        o_psel    = 1'b1;
        o_penable = 1'b1;
        if (complete || timed_out) state_d = ST_RESP;
      end
      ST_RESP: begin
        o_rsp_valid = 1'b1;
        if (i_rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Bus fields move only on acceptance, so the APB lines stay quiet while idle.
  always_ff @(posedge i_clk or negedge i_pnreset) begin
    if (!i_pnreset) begin
      o_paddr  <= '0;
      o_pwrite <= 1'b0;
      o_pwdata <= '0;
    end else if (accept) begin
      o_paddr  <= i_req_addr;
      o_pwrite <= i_req_write;
      o_pwdata <= i_req_wdata;
    end
  end

  // Response fields are captured once per transfer and held through RESP.
  always_ff @(posedge i_clk or negedge i_pnreset) begin
    if (!i_pnreset) begin
      o_rsp_rdata <= '0;
      o_rsp_err   <= 1'b0;
    end else if (complete) begin
      o_rsp_rdata <= o_pwrite ? 32'd0 : i_prdata;
      o_rsp_err   <= i_pslverr;
    end else if (timed_out) begin
      o_rsp_rdata <= 32'd0;
      o_rsp_err   <= 1'b1;
    end
  end

endmodule

// File: tb/tb_dma_master_apb3.sv
// Self-checking bench for dma_master_apb3: vector table through a scoreboard plus
// hand-written stall, reset and (with DMA_MASTER_APB3_TIMEOUT_EN) timeout sequences.
module tb_dma_master_apb3;

  logic        i_clk = 1'b0;
  logic        i_pnreset = 1'b0;
  logic        i_req_valid = 1'b0;
  logic        o_req_ready;
  logic [31:0] i_req_addr = '0;
  logic        i_req_write = 1'b0;
  logic [31:0] i_req_wdata = '0;
  logic        o_rsp_valid;
  logic        i_rsp_ready = 1'b0;
  logic [31:0] o_rsp_rdata;
  logic        o_rsp_err;
  logic        o_psel;
  logic        o_penable;
  logic [31:0] o_paddr;
  logic        o_pwrite;
  logic [31:0] o_pwdata;
  logic        i_pready = 1'b0;
  logic        i_pslverr = 1'b0;
  logic [31:0] i_prdata = '0;
  logic        o_busy;

  dma_master_apb3 #(.TIMEOUT(4)) dut (
    .i_clk       (i_clk),
    .i_pnreset   (i_pnreset),
    .i_req_valid (i_req_valid),
    .o_req_ready (o_req_ready),
    .i_req_addr  (i_req_addr),
    .i_req_write (i_req_write),
    .i_req_wdata (i_req_wdata),
    .o_rsp_valid (o_rsp_valid),
    .i_rsp_ready (i_rsp_ready),
    .o_rsp_rdata (o_rsp_rdata),
    .o_rsp_err   (o_rsp_err),
    .o_psel      (o_psel),
    .o_penable   (o_penable),
    .o_paddr     (o_paddr),
    .o_pwrite    (o_pwrite),
    .o_pwdata    (o_pwdata),
    .i_pready    (i_pready),
    .i_pslverr   (i_pslverr),
    .i_prdata    (i_prdata),
    .o_busy      (o_busy)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          waits;
    logic        slverr;
    logic [31:0] prdata;
    logic        exp_err;
    logic [31:0] exp_rdata;
  } vec_t;

  typedef struct {
    logic        err;
    logic [31:0] rdata;
  } rsp_t;

  rsp_t sb_q[$];
  int   n_checks = 0;
  int   n_errs   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  // Starts and ends just after a rising edge with the DUT in IDLE.
  task automatic run_cmd(input vec_t v);
    int   busy;
    int   extra;
    rsp_t exp;
    busy        = 0;
    i_req_valid = 1'b1;
    i_req_addr  = v.addr;
    i_req_write = v.write;
    i_req_wdata = v.wdata;
    @(negedge i_clk);
    check_bit("req_ready_idle", o_req_ready, 1'b1);
    check_bit("busy_idle", o_busy, 1'b0);
    @(posedge i_clk); #1;
    sb_q.push_back('{err: v.exp_err, rdata: v.exp_rdata});
    i_req_valid = 1'b0;
    i_req_addr  = $urandom;
    i_req_wdata = $urandom;
    i_req_write = ~v.write;
    @(negedge i_clk);
    check_bit("setup_psel", o_psel, 1'b1);
    check_bit("setup_penable", o_penable, 1'b0);
    check("setup_paddr", o_paddr, v.addr);
    check_bit("setup_pwrite", o_pwrite, v.write);
    check("setup_pwdata", o_pwdata, v.wdata);
    if (o_busy) busy++;
    @(posedge i_clk); #1;
    for (int i = 0; i <= v.waits; i++) begin
      i_pready  = (i == v.waits);
      i_pslverr = (i == v.waits) ? v.slverr : ((i % 2) == 0);
      i_prdata  = (i == v.waits) ? v.prdata : $urandom;
      @(negedge i_clk);
      check_bit("access_psel", o_psel, 1'b1);
      check_bit("access_penable", o_penable, 1'b1);
      check("access_paddr", o_paddr, v.addr);
      check("access_pwdata", o_pwdata, v.wdata);
      check_bit("access_no_rsp", o_rsp_valid, 1'b0);
      if (o_busy) busy++;
      @(posedge i_clk); #1;
    end
    i_pready    = 1'b0;
    i_pslverr   = 1'b1;
    i_prdata    = $urandom;
    i_rsp_ready = 1'b1;
    extra       = 0;
    @(negedge i_clk);
    while (!o_rsp_valid && extra < 4) begin
      if (o_busy) busy++;
      @(negedge i_clk);
      extra++;
    end
    check("rsp_latency", 32'(extra), 32'd0);
    if (o_rsp_valid) begin
      exp = sb_q.pop_front();
      check_bit("rsp_err", o_rsp_err, exp.err);
      check("rsp_rdata", o_rsp_rdata, exp.rdata);
      check_bit("rsp_psel_low", o_psel, 1'b0);
      check("rsp_paddr_held", o_paddr, v.addr);
    end
    if (o_busy) busy++;
    @(posedge i_clk); #1;
    i_rsp_ready = 1'b0;
    @(negedge i_clk);
    check_bit("back_idle", o_req_ready, 1'b1);
    check("busy_cycles", 32'(busy), 32'(v.waits + 3));
    @(posedge i_clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t vecs[5];
    vec_t v;
    rsp_t exp;
    int   n;

    vecs[0] = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 0, 1'b0, 32'hFFFF_FFFF, 1'b0, 32'h0};
    vecs[1] = '{1'b0, 32'h0000_0024, 32'h0000_0000, 3, 1'b0, 32'h1234_5678, 1'b0, 32'h1234_5678};
    vecs[2] = '{1'b0, 32'h0000_0030, 32'h0101_0101, 2, 1'b1, 32'hA5A5_5A5A, 1'b1, 32'hA5A5_5A5A};
    vecs[3] = '{1'b1, 32'h0000_0003, 32'h0BAD_F00D, 1, 1'b1, 32'h1111_1111, 1'b1, 32'h0};
    vecs[4] = '{1'b0, 32'hFFFF_FFFE, 32'h0000_0000, 0, 1'b0, 32'h8000_0001, 1'b0, 32'h8000_0001};

    // Reset values
    #1;
    check_bit("rst_psel", o_psel, 1'b0);
    check_bit("rst_penable", o_penable, 1'b0);
    check_bit("rst_pwrite", o_pwrite, 1'b0);
    check_bit("rst_rsp_valid", o_rsp_valid, 1'b0);
    check_bit("rst_rsp_err", o_rsp_err, 1'b0);
    check_bit("rst_busy", o_busy, 1'b0);
    check("rst_paddr", o_paddr, 32'h0);
    check("rst_pwdata", o_pwdata, 32'h0);
    check("rst_rsp_rdata", o_rsp_rdata, 32'h0);
    repeat (2) @(posedge i_clk);
    #1;
    i_pnreset = 1'b1;
    @(negedge i_clk);
    check_bit("rst_req_ready", o_req_ready, 1'b1);
    @(posedge i_clk); #1;

    foreach (vecs[i]) run_cmd(vecs[i]);

    // Response stall with a competing command held on the request channel
    i_req_valid = 1'b1;
    i_req_addr  = 32'h0000_0040;
    i_req_write = 1'b0;
    i_req_wdata = 32'h7777_0000;
    @(posedge i_clk); #1;
    sb_q.push_back('{err: 1'b0, rdata: 32'hCAFE_F00D});
    i_req_addr  = 32'h0000_0080;
    i_req_write = 1'b1;
    i_req_wdata = 32'h0000_0080;
    @(posedge i_clk); #1;
    i_pready  = 1'b1;
    i_pslverr = 1'b0;
    i_prdata  = 32'hCAFE_F00D;
    @(posedge i_clk); #1;
    i_pready  = 1'b0;
    i_pslverr = 1'b1;
    i_prdata  = $urandom;
    exp = sb_q.pop_front();
    for (int k = 0; k < 5; k++) begin
      @(negedge i_clk);
      check_bit("stall_rsp_valid", o_rsp_valid, 1'b1);
      check_bit("stall_req_ready", o_req_ready, 1'b0);
      check_bit("stall_psel", o_psel, 1'b0);
      check_bit("stall_penable", o_penable, 1'b0);
      check("stall_rdata", o_rsp_rdata, exp.rdata);
      check_bit("stall_err", o_rsp_err, exp.err);
      check("stall_paddr", o_paddr, 32'h0000_0040);
      @(posedge i_clk); #1;
    end
    i_rsp_ready = 1'b1;
    @(negedge i_clk);
    check_bit("stall_release_valid", o_rsp_valid, 1'b1);
    @(posedge i_clk); #1;
    i_rsp_ready = 1'b0;
    v = '{1'b1, 32'h0000_0080, 32'h0000_0080, 0, 1'b0, 32'h0, 1'b0, 32'h0};
    run_cmd(v);

    // Asynchronous reset in the middle of ACCESS
    i_req_valid = 1'b1;
    i_req_addr  = 32'h0000_0050;
    i_req_write = 1'b1;
    i_req_wdata = 32'h0000_5050;
    @(posedge i_clk); #1;
    i_req_valid = 1'b0;
    @(posedge i_clk); #1;
    i_pready = 1'b0;
    @(negedge i_clk);
    check_bit("pre_reset_penable", o_penable, 1'b1);
    #2;
    i_pnreset = 1'b0;
    #1;
    check_bit("mid_reset_psel", o_psel, 1'b0);
    check_bit("mid_reset_penable", o_penable, 1'b0);
    check_bit("mid_reset_busy", o_busy, 1'b0);
    check_bit("mid_reset_rsp_valid", o_rsp_valid, 1'b0);
    check("mid_reset_paddr", o_paddr, 32'h0);
    check("mid_reset_pwdata", o_pwdata, 32'h0);
    @(posedge i_clk); #1;
    i_pnreset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge i_clk);
      check_bit("post_reset_no_rsp", o_rsp_valid, 1'b0);
      check_bit("post_reset_psel", o_psel, 1'b0);
      @(posedge i_clk); #1;
    end
    v = '{1'b0, 32'h0000_0054, 32'h0000_0000, 1, 1'b0, 32'h0F0F_F0F0, 1'b0, 32'h0F0F_F0F0};
    run_cmd(v);

`ifdef DMA_MASTER_APB3_TIMEOUT_EN
    // Slave never answers: forced termination after TIMEOUT ACCESS cycles
    i_req_valid = 1'b1;
    i_req_addr  = 32'h0000_0060;
    i_req_write = 1'b0;
    @(posedge i_clk); #1;
    sb_q.push_back('{err: 1'b1, rdata: 32'h0});
    i_req_valid = 1'b0;
    @(posedge i_clk); #1;
    i_pready  = 1'b0;
    i_pslverr = 1'b0;
    i_prdata  = 32'hDEAD_0000;
    n = 0;
    @(negedge i_clk);
    while (o_penable && n < 20) begin
      n++;
      @(negedge i_clk);
    end
    check("timeout_access_cycles", 32'(n), 32'd4);
    check_bit("timeout_rsp_valid", o_rsp_valid, 1'b1);
    check_bit("timeout_psel", o_psel, 1'b0);
    if (o_rsp_valid) begin
      exp = sb_q.pop_front();
      check_bit("timeout_err", o_rsp_err, exp.err);
      check("timeout_rdata", o_rsp_rdata, exp.rdata);
    end
    i_rsp_ready = 1'b1;
    @(posedge i_clk); #1;
    i_rsp_ready = 1'b0;
    @(negedge i_clk);
    check_bit("timeout_back_idle", o_req_ready, 1'b1);
    @(posedge i_clk); #1;
`else
    n = 0;
`endif

    check("scoreboard_empty", 32'(sb_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
